// File: rtl/sorter_pkg.sv
// rtl/sorter_pkg.sv - shared state encoding and record constants for the merge-tree feeder
package sorter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } feeder_state_t;

  localparam int SENTINEL_W = 64;
  localparam logic [SENTINEL_W-1:0] SENTINEL = '1;

  function automatic int pad_width(input int datw, input int keyw);
    return datw - keyw;
  endfunction

endpackage

// File: rtl/feeder_req_fifo.sv
// rtl/feeder_req_fifo.sv - way-index request FIFO with registered full/empty flags
module feeder_req_fifo #(
  parameter int Q_SIZE = 2,
  parameter int WIDTH  = 6
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [Q_SIZE:0]  count,
  output logic             overflow
);

  localparam int DEPTH = 1 << Q_SIZE;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [Q_SIZE-1:0] wr_ptr;
  logic [Q_SIZE-1:0] rd_ptr;
  logic [Q_SIZE:0]   count_nxt;
  logic              do_wr;
  logic              do_rd;

  // A write into a full FIFO is only safe when the head slot frees up this cycle.
  assign do_rd    = rd_en && !empty;
  assign do_wr    = wr_en && (!full || do_rd);
  assign overflow = wr_en && full && !do_rd;
  assign rd_data  = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    case ({do_wr, do_rd})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == (Q_SIZE+1)'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  always_ff @(posedge CLK) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/tree_way_feeder.sv
// rtl/tree_way_feeder.sv - memory-side leaf feeder: per-way key fetch with sentinel on exhaustion
module tree_way_feeder
  import sorter_pkg::*;
#(
  parameter int W_LOG   = 6,
  parameter int Q_SIZE  = 2,
  parameter int DATW    = 64,
  parameter int KEYW    = 32,
  parameter int LEN_LOG = 10,
  parameter int MEM_LAT = 1
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     START,
  input  logic [LEN_LOG:0]         CFG_LEN,
  input  logic [W_LOG-1:0]         I_REQUEST,
  input  logic                     I_REQUEST_VALID,
  output logic                     O_QUEUE_FULL,
  output logic                     MEM_RE,
  output logic [W_LOG+LEN_LOG-1:0] MEM_RADDR,
  input  logic [KEYW-1:0]          MEM_RDATA,
  output logic [DATW-1:0]          DOT,
  output logic                     DOTEN,
  output logic [W_LOG-1:0]         DOT_IDX,
  output logic                     O_DONE,
  output logic                     O_ERR
);

  localparam int NWAYS = 1 << W_LOG;
  localparam int PAD_W = pad_width(DATW, KEYW);
  localparam logic [DATW-1:0] SENT = '1;

  feeder_state_t state;
  feeder_state_t state_nxt;

  logic [LEN_LOG:0] cfg_len;
  logic [LEN_LOG:0] cnt [NWAYS];
  logic [W_LOG:0]   exh_cnt;
  logic             done_q;
  logic             err_q;

  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_ovf;
  logic [Q_SIZE:0]  fifo_cnt;
  logic [W_LOG-1:0] way;

  logic             start_ok;
  logic             deq;
  logic             live;
  logic             last_key;

  logic [MEM_LAT-1:0] pipe_v;
  logic [MEM_LAT-1:0] pipe_s;
  logic [W_LOG-1:0]   pipe_idx [MEM_LAT];
  logic               pipe_busy;
  logic [DATW-1:0]    key_rec;

  feeder_req_fifo #(
    .Q_SIZE (Q_SIZE),
    .WIDTH  (W_LOG)
  ) u_req_fifo (
    .CLK      (CLK),
    .RST      (RST),
    .wr_en    (I_REQUEST_VALID),
    .wr_data  (I_REQUEST),
    .rd_en    (deq),
    .rd_data  (way),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_cnt),
    .overflow (fifo_ovf)
  );

  assign start_ok  = START && (state == IDLE);
  assign deq       = (state == RUN) && !fifo_empty;
  assign live      = (cnt[way] != cfg_len);
  assign last_key  = live && ((cnt[way] + 1'b1) == cfg_len);
  assign pipe_busy = |pipe_v;

  if (PAD_W > 0) begin : g_pad
    assign key_rec = {{PAD_W{1'b1}}, MEM_RDATA};
  end else begin : g_nopad
    assign key_rec = MEM_RDATA;
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (START) state_nxt = RUN;
      RUN:     if (done_q && (fifo_cnt == '0) && !pipe_busy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    MEM_RE    = deq && live;
    MEM_RADDR = '0;
    if (deq && live) MEM_RADDR = {way, cnt[way][LEN_LOG-1:0]};
    DOTEN   = pipe_v[MEM_LAT-1];
    DOT_IDX = '0;
    DOT     = '0;
    if (pipe_v[MEM_LAT-1]) begin
      DOT_IDX = pipe_idx[MEM_LAT-1];
      DOT     = pipe_s[MEM_LAT-1] ? SENT : key_rec;
    end
  end

  assign O_QUEUE_FULL = fifo_full;
  assign O_DONE       = done_q;
  assign O_ERR        = err_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      cfg_len <= '0;
      exh_cnt <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < NWAYS; i++) cnt[i] <= '0;
    end else begin
      if (fifo_ovf) err_q <= 1'b1;
      if (start_ok) begin
        cfg_len <= CFG_LEN;
        exh_cnt <= '0;
        done_q  <= 1'b0;
        for (int i = 0; i < NWAYS; i++) cnt[i] <= '0;
      end else if (deq && live) begin
        cnt[way] <= cnt[way] + 1'b1;
        if (last_key) begin
          exh_cnt <= exh_cnt + 1'b1;
          done_q  <= ((exh_cnt + 1'b1) == (W_LOG+1)'(NWAYS));
        end
      end
    end
  end

  // Way tag and sentinel flag ride alongside the memory read so the record lines up with MEM_RDATA.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pipe_v <= '0;
      pipe_s <= '0;
      for (int i = 0; i < MEM_LAT; i++) pipe_idx[i] <= '0;
    end else begin
      pipe_v[0]   <= deq;
      pipe_s[0]   <= !live;
      pipe_idx[0] <= way;
      for (int i = 1; i < MEM_LAT; i++) begin
        pipe_v[i]   <= pipe_v[i-1];
        pipe_s[i]   <= pipe_s[i-1];
        pipe_idx[i] <= pipe_idx[i-1];
      end
    end
  end

endmodule
